// File: rtl/instruction_issuer_if.sv
//==============================================================================
// Module   : instruction_issuer_if
// Brief    : Controller write port and issued-instruction bus of the issuer.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface instruction_issuer_if #(
   parameter int DEPTH = 4
);
   localparam int c_CNT_W = $clog2(DEPTH) + 1;

   logic               wr_valid;
   logic               wr_ready;
   logic [2:0]         wr_src;
   logic [2:0]         wr_dst;
   logic [2:0]         wr_delay;
   logic               enable;
   logic               flush;
   logic [8:0]         instruct;
   logic               issue_valid;
   logic               issue_start;
   logic               done;
   logic [c_CNT_W-1:0] count;

   modport master (
      output wr_valid, wr_src, wr_dst, wr_delay, enable, flush,
      input  wr_ready, instruct, issue_valid, issue_start, done, count
   );

   modport slave (
      input  wr_valid, wr_src, wr_dst, wr_delay, enable, flush,
      output wr_ready, instruct, issue_valid, issue_start, done, count
   );
endinterface

`default_nettype wire

// File: rtl/instruction_issuer.sv
//==============================================================================
// Module   : instruction_issuer
// Brief    : FIFO-buffered issuer holding each {delay,dst,src} instruction
//            stable for max(delay,MIN_DELAY)+1 cycles.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module instruction_issuer #(
   parameter int DEPTH     = 4,
   parameter int MIN_DELAY = 3
) (
   input  wire logic              clk,
   input  wire logic              reset_n,
   instruction_issuer_if.slave    bus
);
   localparam int                 c_AW       = $clog2(DEPTH);
   localparam int                 c_CW       = c_AW + 1;
   localparam logic [c_CW-1:0]    c_FULL     = c_CW'(DEPTH);
   localparam logic [c_CW-1:0]    c_CNT_ONE  = c_CW'(1);
   localparam logic [c_AW-1:0]    c_PTR_ONE  = c_AW'(1);
   localparam logic [2:0]         c_MIN_HOLD = 3'(MIN_DELAY);

   localparam logic [0:0]         c_IDLE     = 1'b0;
   localparam logic [0:0]         c_HOLD     = 1'b1;

   logic [0:0]      r_state;
   logic [0:0]      w_next_state;
   logic [8:0]      r_mem [DEPTH];
   logic [c_AW-1:0] r_wr_ptr;
   logic [c_AW-1:0] r_rd_ptr;
   logic [c_CW-1:0] r_count;
   logic [c_CW-1:0] w_count_next;
   logic [2:0]      r_hold;
   logic [8:0]      r_instruct;
   logic            r_issue_start;
   logic            r_done;
   logic            w_wr_ready;
   logic            w_push;
   logic            w_pop;
   logic            w_issue_valid;
   logic            w_done_next;
   logic [8:0]      w_head;
   logic [2:0]      w_head_hold;

   // wr_ready depends only on registered count, so a same-cycle pop never frees a slot
   assign w_wr_ready  = (r_count < c_FULL) && !bus.flush;
   assign w_push      = bus.wr_valid && w_wr_ready;
   assign w_head      = r_mem[r_rd_ptr];
   assign w_head_hold = (w_head[8:6] > c_MIN_HOLD) ? w_head[8:6] : c_MIN_HOLD;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_pop        = 1'b0;
      case (r_state)
         c_IDLE: begin
            if ((r_count != '0) && bus.enable) begin
               w_pop        = 1'b1;
               w_next_state = c_HOLD;
            end
         end
         c_HOLD: begin
            if (r_hold == 3'd0) begin
               if ((r_count != '0) && bus.enable) begin
                  w_pop = 1'b1;
               end else begin
                  w_next_state = c_IDLE;
               end
            end
         end
         default: w_next_state = c_IDLE;
      endcase
   end

   always_comb begin
      w_count_next = r_count;
      if (bus.flush) begin
         w_count_next = '0;
      end else begin
         case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + c_CNT_ONE;
            2'b01:   w_count_next = r_count - c_CNT_ONE;
            default: w_count_next = r_count;
         endcase
      end
   end

   always_comb begin
      w_issue_valid = (r_state == c_HOLD);
      w_done_next   = (r_state == c_HOLD) && (w_next_state == c_IDLE) &&
                      (w_count_next == '0);
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {bus.wr_delay, bus.wr_dst, bus.wr_src};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_hold        <= 3'd0;
         r_instruct    <= 9'h000;
         r_issue_start <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         r_count       <= w_count_next;
         r_issue_start <= w_pop;
         r_done        <= w_done_next;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         end
         // Flush blocks pushes, so dropping everything left means catching up to the write pointer
         if (bus.flush) begin
            r_rd_ptr <= r_wr_ptr;
         end else if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
         if (w_pop) begin
            r_instruct <= w_head;
            r_hold     <= w_head_hold;
         end else if (r_hold != 3'd0) begin
            r_hold <= r_hold - 3'd1;
         end
      end
   end

   assign bus.wr_ready    = w_wr_ready;
   assign bus.instruct    = r_instruct;
   assign bus.issue_valid = w_issue_valid;
   assign bus.issue_start = r_issue_start;
   assign bus.done        = r_done;
   assign bus.count       = r_count;

endmodule

`default_nettype wire

// File: tb/tb_instruction_issuer.sv
//==============================================================================
// Module   : tb_instruction_issuer
// Brief    : Scoreboard bench for instruction_issuer (DEPTH=4, MIN_DELAY=3).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_instruction_issuer;
   typedef struct {
      logic [8:0]  instr;
      int unsigned hold;
   } exp_t;

   logic clk;
   logic reset_n;
   int   n_tests;
   int   n_fail;
   int   n_start;
   int   n_done;
   exp_t sb[$];

   bit          run_active;
   int unsigned run_len;
   int unsigned run_exp;
   logic [8:0]  run_instr;

   instruction_issuer_if #(.DEPTH(4)) bus ();

   instruction_issuer #(
      .DEPTH     (4),
      .MIN_DELAY (3)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_instr(input logic [2:0] src, input logic [2:0] dst,
                             input logic [2:0] dly, input bit track);
      exp_t e;
      bus.wr_valid = 1'b1;
      bus.wr_src   = src;
      bus.wr_dst   = dst;
      bus.wr_delay = dly;
      @(posedge clk);
      if (track) begin
         e.instr = {dly, dst, src};
         e.hold  = ((dly > 3'd3) ? int'(dly) : 3) + 1;
         sb.push_back(e);
      end
      #1;
      bus.wr_valid = 1'b0;
   endtask

   // Scoreboard consumer: checks order, hold length, stability and done
   always @(negedge clk) begin
      if (!reset_n) begin
         run_active = 1'b0;
      end else begin
         chk("done", bus.done, run_active && !bus.issue_valid && (sb.size() == 0));
         if (bus.done) n_done++;
         if (bus.issue_start) begin
            n_start++;
            if (run_active) chk("hold_len", run_len, run_exp);
            if (sb.size() == 0) begin
               chk("unexpected_issue", bus.instruct, 9'h1ff);
               run_exp = 0;
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("instruct", bus.instruct, e.instr);
               run_exp = e.hold;
            end
            chk("valid_at_start", bus.issue_valid, 1'b1);
            run_active = 1'b1;
            run_len    = 1;
            run_instr  = bus.instruct;
         end else if (bus.issue_valid) begin
            if (!run_active) begin
               chk("valid_without_start", 1'b1, 1'b0);
            end else begin
               run_len++;
               chk("instruct_stable", bus.instruct, run_instr);
            end
         end else if (run_active) begin
            chk("hold_len", run_len, run_exp);
            run_active = 1'b0;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   initial begin
      int len;
      n_tests      = 0;
      n_fail       = 0;
      n_start      = 0;
      n_done       = 0;
      run_active   = 1'b0;
      reset_n      = 1'b0;
      bus.wr_valid = 1'b0;
      bus.wr_src   = 3'd0;
      bus.wr_dst   = 3'd0;
      bus.wr_delay = 3'd0;
      bus.enable   = 1'b0;
      bus.flush    = 1'b0;
      #13;
      reset_n = 1'b1;
      step(1);

      // Reset in the middle of a hold with two entries queued
      bus.enable = 1'b1;
      push_instr(3'd3, 3'd1, 3'd6, 1'b1);
      push_instr(3'd2, 3'd2, 3'd2, 1'b1);
      push_instr(3'd1, 3'd3, 3'd1, 1'b1);
      chk("pre_reset_count", bus.count, 2);
      #2;
      reset_n = 1'b0;
      sb.delete();
      #1;
      chk("rst_instruct", bus.instruct, 9'h000);
      chk("rst_issue_valid", bus.issue_valid, 1'b0);
      chk("rst_count", bus.count, 0);
      chk("rst_issue_start", bus.issue_start, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      step(1);
      reset_n = 1'b1;
      #1;
      chk("rst_wr_ready", bus.wr_ready, 1'b1);
      step(2);

      // Single write, hold clamped to 4 cycles
      n_start = 0; n_done = 0;
      push_instr(3'd5, 3'd2, 3'd0, 1'b1);
      step(8);
      chk("single_starts", n_start, 1);
      chk("single_dones", n_done, 1);
      chk("idle_keeps_instruct", bus.instruct, 9'h015);

      // Back-to-back: 7 + 4 cycles, no gap
      n_start = 0; n_done = 0;
      push_instr(3'd3, 3'd1, 3'd6, 1'b1);
      push_instr(3'd0, 3'd7, 3'd3, 1'b1);
      len = 0;
      for (int i = 0; i < 30; i++) begin
         if (!bus.issue_valid) break;
         len++;
         step(1);
      end
      chk("b2b_total_valid", len, 11);
      step(2);
      chk("b2b_starts", n_start, 2);
      chk("b2b_dones", n_done, 1);

      // Full FIFO with issue disabled; fifth write refused
      n_start = 0; n_done = 0;
      bus.enable = 1'b0;
      push_instr(3'd1, 3'd2, 3'd1, 1'b1);
      push_instr(3'd4, 3'd5, 3'd7, 1'b1);
      push_instr(3'd6, 3'd0, 3'd2, 1'b1);
      push_instr(3'd7, 3'd3, 3'd5, 1'b1);
      chk("full_wr_ready", bus.wr_ready, 1'b0);
      chk("full_count", bus.count, 4);
      push_instr(3'd2, 3'd2, 3'd2, 1'b0);
      chk("full_count_after_5th", bus.count, 4);
      chk("full_no_issue", bus.issue_valid, 1'b0);
      bus.enable = 1'b1;
      step(28);
      chk("full_starts", n_start, 4);
      chk("full_dones", n_done, 1);
      chk("full_drained", sb.size(), 0);

      // Pause: enable dropped in the 2nd cycle of a 7-cycle hold
      n_start = 0; n_done = 0;
      push_instr(3'd1, 3'd4, 3'd6, 1'b1);
      push_instr(3'd2, 3'd6, 3'd2, 1'b1);
      step(1);
      bus.enable = 1'b0;
      step(6);
      chk("pause_idle", bus.issue_valid, 1'b0);
      chk("pause_count", bus.count, 1);
      chk("pause_no_done", n_done, 0);
      step(2);
      chk("pause_still_idle", bus.issue_valid, 1'b0);
      bus.enable = 1'b1;
      step(1);
      chk("resume_start", bus.issue_start, 1'b1);
      chk("resume_count", bus.count, 0);
      step(5);
      chk("pause_starts", n_start, 2);
      chk("pause_dones", n_done, 1);

      // Flush together with a write while 3 are queued behind a live hold
      n_start = 0; n_done = 0;
      push_instr(3'd0, 3'd0, 3'd6, 1'b1);
      push_instr(3'd1, 3'd1, 3'd1, 1'b1);
      push_instr(3'd2, 3'd2, 3'd2, 1'b1);
      push_instr(3'd3, 3'd3, 3'd3, 1'b1);
      chk("flush_pre_count", bus.count, 3);
      bus.flush    = 1'b1;
      bus.wr_valid = 1'b1;
      bus.wr_src   = 3'd7;
      bus.wr_dst   = 3'd7;
      bus.wr_delay = 3'd7;
      #1;
      chk("flush_wr_ready", bus.wr_ready, 1'b0);
      @(posedge clk);
      sb.delete();
      #1;
      bus.flush    = 1'b0;
      bus.wr_valid = 1'b0;
      chk("flush_count", bus.count, 0);
      chk("flush_current_live", bus.issue_valid, 1'b1);
      step(8);
      chk("flush_starts", n_start, 1);
      chk("flush_dones", n_done, 1);
      chk("flush_final_count", bus.count, 0);
      chk("sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
